// File: rtl/cq_viola_nios2_s_div_cell.sv
// Iterative radix-2 restoring divider for div/divu, one quotient bit per cycle.
// Sign handling is done on magnitudes at start and re-applied in a single FIX cycle.
module cq_viola_nios2_s_div_cell #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quotient,
    output logic [WIDTH-1:0] M_div_remainder
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             q_neg;
    logic             r_neg;
    logic             zero_div;

    logic             accept;
    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] src1_mag;
    logic [WIDTH-1:0] src2_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             step_ok;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (M_div_start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (M_div_start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand magnitudes and one restoring step.
    always_comb begin
        src1_neg = M_div_signed & M_div_src1[WIDTH-1];
        src2_neg = M_div_signed & M_div_src2[WIDTH-1];
        src1_mag = src1_neg ? ((~M_div_src1) + WIDTH'(1)) : M_div_src1;
        src2_mag = src2_neg ? ((~M_div_src2) + WIDTH'(1)) : M_div_src2;
        shifted  = {rem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dsr};
        step_ok  = (shifted >= {1'b0, dsr});
        step_rem = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    // Sign restoration; a zero divisor leaves rem equal to the dividend magnitude,
    // so re-applying the dividend sign reproduces the original dividend.
    always_comb begin
        q_fix = q_neg ? ((~dvd) + WIDTH'(1)) : dvd;
        r_fix = r_neg ? ((~rem) + WIDTH'(1)) : rem;
        if (zero_div) begin
            q_fix = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            M_div_busy <= 1'b0;
            M_div_done <= 1'b0;
        end else begin
            M_div_busy <= (state_next == CALC) || (state_next == FIX);
            M_div_done <= (state_next == DONE);
        end
    end

    // Datapath: load on accept, iterate in CALC, publish results in FIX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count           <= '0;
            rem             <= '0;
            dvd             <= '0;
            dsr             <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            zero_div        <= 1'b0;
            M_div_quotient  <= '0;
            M_div_remainder <= '0;
        end else if (accept) begin
            count    <= CW'(WIDTH - 1);
            rem      <= '0;
            dvd      <= src1_mag;
            dsr      <= src2_mag;
            q_neg    <= src1_neg ^ src2_neg;
            r_neg    <= src1_neg;
            zero_div <= (M_div_src2 == '0);
        end else if (state == CALC) begin
            rem <= step_rem;
            dvd <= {dvd[WIDTH-2:0], step_ok};
            if (count != '0) begin
                count <= count - CW'(1);
            end
        end else if (state == FIX) begin
            M_div_quotient  <= q_fix;
            M_div_remainder <= r_fix;
        end
    end

endmodule

// File: tb/tb_cq_viola_nios2_s_div_cell.sv
// Directed bench for cq_viola_nios2_s_div_cell: vector table plus hand-written
// sequences for ignored starts, back-to-back throughput and mid-operation reset.
module tb_cq_viola_nios2_s_div_cell;

    logic        clk;
    logic        reset_n;
    logic        M_div_start;
    logic        M_div_signed;
    logic [31:0] M_div_src1;
    logic [31:0] M_div_src2;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_quotient;
    logic [31:0] M_div_remainder;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] prev_q = 32'h0;
    logic [31:0] prev_r = 32'h0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[11];

    cq_viola_nios2_s_div_cell #(.WIDTH(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .M_div_start     (M_div_start),
        .M_div_signed    (M_div_signed),
        .M_div_src1      (M_div_src1),
        .M_div_src2      (M_div_src2),
        .M_div_busy      (M_div_busy),
        .M_div_done      (M_div_done),
        .M_div_quotient  (M_div_quotient),
        .M_div_remainder (M_div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One divide started in cycle 0; checks latency, busy length, hold and results.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input string name);
        int done_cyc;
        int busy_n;
        done_cyc = -1;
        busy_n   = 0;
        @(posedge clk); #1;
        M_div_signed = sgn;
        M_div_src1   = a;
        M_div_src2   = b;
        M_div_start  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            M_div_start = 1'b0;
            if (M_div_busy) busy_n++;
            if (c == 10) begin
                check({name, " q hold"}, M_div_quotient, prev_q);
                check({name, " r hold"}, M_div_remainder, prev_r);
            end
            if (M_div_done) begin
                done_cyc = c;
                break;
            end
        end
        check({name, " latency"}, 32'(done_cyc), 32'd34);
        check({name, " busy cycles"}, 32'(busy_n), 32'd33);
        check({name, " quotient"}, M_div_quotient, eq);
        check({name, " remainder"}, M_div_remainder, er);
        @(posedge clk); #1;
        check({name, " done one cycle"}, {31'd0, M_div_done}, 32'd0);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int first_done;
        int second_done;
        int n_done;
        int busy_seen;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[3]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234};
        vecs[4]  = '{1'b1, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
        vecs[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
        vecs[10] = '{1'b0, 32'hDEADBEEF,   32'd16,         32'h0DEADBEE,   32'hF};

        reset_n      = 1'b1;
        M_div_start  = 1'b0;
        M_div_signed = 1'b0;
        M_div_src1   = 32'h0;
        M_div_src2   = 32'h0;
        #2 reset_n = 1'b0;
        #1;
        check("reset busy", {31'd0, M_div_busy}, 32'd0);
        check("reset done", {31'd0, M_div_done}, 32'd0);
        check("reset quotient", M_div_quotient, 32'd0);
        check("reset remainder", M_div_remainder, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                    $sformatf("vec%0d", i));
        end

        // Starts during CALC are ignored; a start presented in DONE chains directly.
        first_done  = -1;
        second_done = -1;
        n_done      = 0;
        @(posedge clk); #1;
        M_div_signed = 1'b0;
        M_div_src1   = 32'hFFFFFFFF;
        M_div_src2   = 32'd1;
        M_div_start  = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk); #1;
            M_div_start = 1'b0;
            if (c == 5 || c == 20) begin
                M_div_start = 1'b1;
                M_div_src1  = 32'd3;
                M_div_src2  = 32'd3;
            end
            if (M_div_done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    check("b2b first quotient", M_div_quotient, 32'hFFFFFFFF);
                    check("b2b first remainder", M_div_remainder, 32'd0);
                    M_div_start  = 1'b1;
                    M_div_signed = 1'b0;
                    M_div_src1   = 32'd100;
                    M_div_src2   = 32'd7;
                end else begin
                    second_done = c;
                    check("b2b second quotient", M_div_quotient, 32'd14);
                    check("b2b second remainder", M_div_remainder, 32'd2);
                    break;
                end
            end
        end
        check("b2b first done cycle", 32'(first_done), 32'd34);
        check("b2b second done cycle", 32'(second_done), 32'd68);
        check("b2b done count", 32'(n_done), 32'd2);
        prev_q = 32'd14;
        prev_r = 32'd2;
        @(posedge clk); #1;

        // Reset at cycle 10 aborts the divide with no later done pulse.
        M_div_signed = 1'b0;
        M_div_src1   = 32'd50;
        M_div_src2   = 32'd5;
        M_div_start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            M_div_start = 1'b0;
        end
        check("abort busy before reset", {31'd0, M_div_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort busy", {31'd0, M_div_busy}, 32'd0);
        check("abort done", {31'd0, M_div_done}, 32'd0);
        check("abort quotient", M_div_quotient, 32'd0);
        check("abort remainder", M_div_remainder, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_done    = 0;
        busy_seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (M_div_done) n_done++;
            if (M_div_busy) busy_seen++;
        end
        check("abort no done", 32'(n_done), 32'd0);
        check("abort no busy", 32'(busy_seen), 32'd0);
        prev_q = 32'd0;
        prev_r = 32'd0;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
